pll_clk_manager: RTL

- Single-clock supervisor for a Gowin rPLL instance. Pulses the PLL's reset input and watches its LOCK output. Holds downstream logic in reset until lock has been stable for a set time.
- Once running, generates CHANNELS independent clock-enable strobes with runtime-programmable divide ratios.
- Runs on the fabric reference clock (27 MHz on TangNano9k). Sits between the rPLL wrapper and the board top level.

---
 rtl/pll_clk_manager.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pll_clk_manager.sv
// PLL supervisor: pulses rPLL reset, qualifies LOCK, releases downstream reset and
// generates programmable clock-enable strobes. Optional macro: PLL_CLK_MANAGER_LOCK_FILTER_EN.
module pll_clk_manager #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 256
) (
  input  logic                      clkin,
  input  logic                      resetn,
  input  logic                      pll_lock,
  output logic                      pll_reset,
  output logic                      rst_out_n,
  output logic                      locked,
  input  logic [CHANNELS*DIV_W-1:0] div_ratio,
  output logic [CHANNELS-1:0]       ce,
  output logic [7:0]                relock_count
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             lock_s;
  logic             run_loss_c;
  logic             pll_reset_d;
  logic             rst_out_n_d;
  logic             locked_d;

  // Two-flop synchroniser for the asynchronous LOCK input
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end

`ifdef PLL_CLK_MANAGER_LOCK_FILTER_EN
  // In RUN, lock loss requires four consecutive low samples
  logic [1:0] low_cnt;

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      low_cnt <= 2'd0;
    end else if (state != S_RUN || lock_s) begin
      low_cnt <= 2'd0;
    end else if (low_cnt != 2'd3) begin
      low_cnt <= low_cnt + 2'd1;
    end
  end

  assign run_loss_c = !lock_s && (low_cnt == 2'd3);
`else
  assign run_loss_c = !lock_s;
`endif

  // State register with outputs registered from the next-state decode
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state     <= S_RESET_PLL;
      pll_reset <= 1'b1;
      rst_out_n <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= next_state;
      pll_reset <= pll_reset_d;
      rst_out_n <= rst_out_n_d;
      locked    <= locked_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET_PLL: begin
        if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) next_state = S_STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) next_state = S_RESET_PLL;
      end
      S_STABLE: begin
        if (!lock_s) next_state = S_WAIT_LOCK;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1)) next_state = S_RUN;
      end
      S_RUN: begin
        if (run_loss_c) next_state = S_RESET_PLL;
      end
      default: next_state = S_RESET_PLL;
    endcase
  end

  always_comb begin
    pll_reset_d = 1'b0;
    rst_out_n_d = 1'b0;
    locked_d    = 1'b0;
    case (next_state)
      S_RESET_PLL: pll_reset_d = 1'b1;
      S_RUN: begin
        rst_out_n_d = 1'b1;
        locked_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared phase counter, restarted on every state entry and idle in RUN
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (next_state != state || state == S_RUN) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Retry / lock-loss counter, saturating
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      relock_count <= 8'd0;
    end else if (next_state == S_RESET_PLL && state != S_RESET_PLL && relock_count != 8'hFF) begin
      relock_count <= relock_count + 8'd1;
    end
  end

  // Per-channel dividers; ce is computed from the counter value of the coming cycle
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] ratio_c;
    logic [DIV_W-1:0] lim_c;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] cnt_q;
    logic             ce_q;

    assign ratio_c = div_ratio[i*DIV_W +: DIV_W];
    assign lim_c   = (ratio_c == '0) ? '0 : ratio_c - DIV_W'(1);
    assign cnt_d   = (state != S_RUN || ce_q) ? '0 : cnt_q + DIV_W'(1);

    always_ff @(posedge clkin) begin
      if (!resetn) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else if (next_state != S_RUN) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ce_q  <= (cnt_d >= lim_c);
      end
    end

    assign ce[i] = ce_q;
  end

endmodule
